// File: rtl/wb_arbiter_wdt.sv
// wb_arbiter_wdt: round-robin Wishbone bus arbiter with a transfer watchdog.
// The arbiter owns the grant select consumed by the interconnect datapath.
// The optional watchdog is compiled in when WB_ARB_WDT_EN is defined. It ends
// a transfer that is never acknowledged: it pulses a bus error to the owner
// and masks the stalled strobe until the owner lets go of it.
// Without WB_ARB_WDT_EN the bus is held until the owner drops cyc. In that
// build to_err_o, stb_mask_o and timeout_count_o are constant zero.
module wb_arbiter_wdt #(
  parameter int MASTERS_NUM    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [MASTERS_NUM-1:0]         m_cyc_i,
  input  logic [MASTERS_NUM-1:0]         m_stb_i,
  input  logic                           s_ack_i,
  input  logic                           s_err_i,
  output logic [MASTERS_NUM-1:0]         grant_o,
  output logic [$clog2(MASTERS_NUM)-1:0] grant_idx_o,
  output logic                           grant_valid_o,
  output logic                           stb_mask_o,
  output logic [MASTERS_NUM-1:0]         to_err_o,
  output logic [7:0]                     timeout_count_o
);

  localparam int IDXW = $clog2(MASTERS_NUM);

`ifdef WB_ARB_WDT_EN
  localparam int WDTW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_TIMEOUT,
    ST_DRAIN
  } state_e;
`else
  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } state_e;
`endif

  state_e                 state_q, state_d;
  logic [MASTERS_NUM-1:0] grant_q, grant_d;
  logic [IDXW-1:0]        grant_idx_q, grant_idx_d;
  logic [IDXW-1:0]        rr_last_q, rr_last_d;

`ifdef WB_ARB_WDT_EN
  logic [WDTW-1:0]        wdt_q, wdt_d;
  logic [MASTERS_NUM-1:0] to_err_q, to_err_d;
  logic                   stb_mask_q, stb_mask_d;
  logic [7:0]             count_q, count_d;
  logic                   owner_stb;
  logic                   wdt_inc;
`endif

  logic                   owner_cyc;
  logic                   pick_valid;
  logic [IDXW-1:0]        pick_idx;
  logic [MASTERS_NUM-1:0] pick_onehot;
  logic [IDXW:0]          cand_wide;
  logic [IDXW-1:0]        cand_idx;

  // The owner's request lines, selected with the one-hot grant. Only the owner
  // is looked at while the bus is held.
  assign owner_cyc = |(m_cyc_i & grant_q);

`ifdef WB_ARB_WDT_EN
  assign owner_stb = |(m_stb_i & grant_q);
  // The watchdog only advances while the owner strobes and the slave is silent.
  assign wdt_inc   = owner_stb && !s_ack_i && !s_err_i;
`else
  logic unused_inputs;
  assign unused_inputs = ^{m_stb_i, s_ack_i, s_err_i, 32'(TIMEOUT_CYCLES)};
`endif

  // Round-robin pick: scan upward from the master after rr_last and wrap, so
  // the master that was served last has the lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_wide  = '0;
    cand_idx   = '0;
    for (int k = 1; k <= MASTERS_NUM; k++) begin
      cand_wide = {1'b0, rr_last_q} + (IDXW+1)'(k);
      if (cand_wide >= (IDXW+1)'(MASTERS_NUM)) begin
        cand_wide = cand_wide - (IDXW+1)'(MASTERS_NUM);
      end
      cand_idx = cand_wide[IDXW-1:0];
      if (!pick_valid && m_cyc_i[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Decode of the picked index into the one-hot grant vector.
  for (genvar gi = 0; gi < MASTERS_NUM; gi++) begin : g_onehot
    assign pick_onehot[gi] = (pick_idx == IDXW'(gi));
  end

  // Next-state and next-output logic for the ownership and watchdog FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    rr_last_d   = rr_last_q;
`ifdef WB_ARB_WDT_EN
    wdt_d       = wdt_q;
    to_err_d    = '0;
    stb_mask_d  = stb_mask_q;
    count_d     = count_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_OWNED;
          grant_d     = pick_onehot;
          grant_idx_d = pick_idx;
          rr_last_d   = pick_idx;
        end
      end
      ST_OWNED: begin
        // A release wins over a timeout that matures in the same cycle.
        if (!owner_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
`ifdef WB_ARB_WDT_EN
          wdt_d   = '0;
`endif
        end
`ifdef WB_ARB_WDT_EN
        else if (wdt_inc && (wdt_q == WDTW'(TIMEOUT_CYCLES - 1))) begin
          state_d    = ST_TIMEOUT;
          wdt_d      = '0;
          to_err_d   = grant_q;
          stb_mask_d = 1'b1;
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
        end else if (wdt_inc) begin
          wdt_d = wdt_q + WDTW'(1);
        end else begin
          wdt_d = '0;
        end
`endif
      end
`ifdef WB_ARB_WDT_EN
      ST_TIMEOUT: begin
        // The error pulse lasts one cycle. The strobe stays masked afterwards.
        if (!owner_cyc) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          stb_mask_d = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A late ack or err stays masked until the owner drops the stalled stb.
        if (!owner_cyc) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          stb_mask_d = 1'b0;
        end else if (!owner_stb) begin
          state_d    = ST_OWNED;
          stb_mask_d = 1'b0;
          wdt_d      = '0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers. Reset leaves master 0 first in the rotation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_last_q   <= IDXW'(MASTERS_NUM - 1);
`ifdef WB_ARB_WDT_EN
      wdt_q       <= '0;
      to_err_q    <= '0;
      stb_mask_q  <= 1'b0;
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_last_q   <= rr_last_d;
`ifdef WB_ARB_WDT_EN
      wdt_q       <= wdt_d;
      to_err_q    <= to_err_d;
      stb_mask_q  <= stb_mask_d;
      count_q     <= count_d;
`endif
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_valid_o = |grant_q;

`ifdef WB_ARB_WDT_EN
  assign to_err_o        = to_err_q;
  assign stb_mask_o      = stb_mask_q;
  assign timeout_count_o = count_q;
`else
  assign to_err_o        = '0;
  assign stb_mask_o      = 1'b0;
  assign timeout_count_o = 8'd0;
`endif

endmodule

// File: doc/wb_arbiter_wdt.md
# wb_arbiter_wdt

Sequencing controller for the shared Wishbone interconnect. It arbitrates bus ownership round-robin among MASTERS_NUM masters and drives the interconnect datapath's grant select. A watchdog terminates any transfer the addressed slave never acknowledges: it returns a bus error to the owning master and masks the stalled strobe. It sits between the masters' cyc/stb lines and the interconnect mux, which consumes its grant and mask outputs.

## Interface
Parameters:
- MASTERS_NUM, 2, number of requesting masters (>= 2)
- TIMEOUT_CYCLES, 256, cycles a strobe may wait for ack/err before timeout (>= 2)

Ports:
- clk_i  in  1  bus clock
- rst_n_i  in  1  reset, asynchronous, active-low
- m_cyc_i  in  MASTERS_NUM  per-master cycle request
- m_stb_i  in  MASTERS_NUM  per-master strobe
- s_ack_i  in  1  ack from currently selected slave (already muxed)
- s_err_i  in  1  err from currently selected slave (already muxed)
- grant_o  out  MASTERS_NUM  one-hot bus owner; all-zero when none
- grant_idx_o  out  $clog2(MASTERS_NUM)  binary owner index for datapath mux
- grant_valid_o  out  1  a master owns the bus
- stb_mask_o  out  1  datapath must gate slave stb and master ack with ~stb_mask_o
- to_err_o  out  MASTERS_NUM  one-cycle timeout error to owner, OR'ed into master err by datapath
- timeout_count_o  out  8  saturating count of timeouts since reset

## Operation
- States: IDLE, OWNED, TIMEOUT, DRAIN. rr_last register holds the index of the last granted master.
- IDLE: if |m_cyc_i, select the first set bit scanning from (rr_last+1) mod MASTERS_NUM upward with wrap. Register grant, set rr_last, go OWNED. Otherwise stay in IDLE with grant_o = 0.
- OWNED: the watchdog counter wdt (width $clog2(TIMEOUT_CYCLES+1)) behaves as follows:
  - Clears to 0 when the owner's stb is low, or when s_ack_i or s_err_i is high.
  - Increments otherwise.
  - If the owner's cyc is low: go IDLE, clear wdt. This takes priority over a timeout in the same cycle.
  - Else if wdt == TIMEOUT_CYCLES-1 and the increment condition holds: go TIMEOUT.
- TIMEOUT: lasts exactly one cycle.
  - to_err_o[owner] = 1 and stb_mask_o = 1.
  - timeout_count_o increments, saturating at 255.
  - Next state is DRAIN. It is IDLE instead if the owner's cyc is low.
- DRAIN: stb_mask_o = 1.
  - Owner's cyc low -> IDLE.
  - Owner's stb low with cyc still high -> OWNED, wdt = 0.
  - Late s_ack_i/s_err_i in TIMEOUT or DRAIN is ignored and remains masked.
- Non-owner cyc/stb are ignored while the bus is owned; there is no preemption.
- grant_idx_o holds its last value in IDLE. grant_valid_o = |grant_o.

## Timing
- Reset (rst_n_i low, asynchronous) forces immediately:
  - state IDLE, wdt 0, rr_last = MASTERS_NUM-1 (so master 0 wins first).
  - Outputs: grant_o 0, grant_idx_o 0, grant_valid_o 0, stb_mask_o 0, to_err_o 0, timeout_count_o 0.
- Reset mid-transfer drops the grant without issuing an error.
- Grant latency: cyc sampled high at edge N in IDLE -> grant_o valid after edge N (one registered stage). All outputs are registered.
- Release: owner cyc sampled low at edge N -> grant_o = 0 after N. The next grant can appear after edge N+1, so there is a minimum of one idle cycle between owners.
- Timeout: a stb stalled from cycle 0 has to_err_o high in cycle TIMEOUT_CYCLES.
- An ack arriving in the same cycle wdt hits TIMEOUT_CYCLES-1 prevents the timeout.
- Simultaneous requests: rotation order only. A master re-requesting immediately after release loses to any other pending requester.

## Configuration
- WB_ARB_WDT_EN defined: watchdog, TIMEOUT/DRAIN states and timeout_count_o as above.
- Not defined:
  - The wdt counter and the TIMEOUT/DRAIN states are removed.
  - to_err_o, stb_mask_o and timeout_count_o are tied to 0.
  - A stalled transfer holds the bus indefinitely.

## Test plan
- Reset, then assert m_cyc_i = 2'b11 -> grant_o = 2'b01 one cycle later. Drop cyc0 -> one idle cycle, then grant_o = 2'b10.
- MASTERS_NUM = 4, all four cyc held, each owner drops cyc after 3 acks -> grant order 0,1,2,3,0.
- TIMEOUT_CYCLES = 8, owner stb high, no ack -> to_err_o[owner] pulses exactly in cycle 8. stb_mask_o stays high until stb drops. timeout_count_o = 1.
- Ack at wdt = 7 with TIMEOUT_CYCLES = 8 -> no error; wdt returns to 0 and the transfer continues.
- Owner cyc drops on the same cycle as the timeout -> no to_err_o, state IDLE. Assert rst_n_i low mid-transfer -> all outputs 0 asynchronously, and master 0 wins after release.
- Build without WB_ARB_WDT_EN, stall 1000 cycles -> to_err_o, stb_mask_o and timeout_count_o stay 0 and the grant is held.
